conv3x3_layer_28x28: RTL

- Valid-padding 3x3 convolution: 28x28 single-channel feature map in, 26x26 map out.
- Sits directly upstream of the 26x26 max-pooling stage. The output map it writes is the pooler's input memory.
- Uses the same memory-style interface: read-address/pixel port toward the input RAM, address/data/write-enable port toward the output RAM.
- Runs start/done driven, fully sequential, one MAC per cycle.

---
 rtl/conv3x3_layer_28x28.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/conv3x3_layer_28x28.sv
// 3x3 valid conv, IN_DIM^2 -> (IN_DIM-2)^2, one MAC per cycle, 11 cycles per output; no backpressure.
// Define CONV_RELU_EN to clamp negative results to zero at write-out.
module conv3x3_layer_28x28 #(
   parameter int IN_DIM    = 28,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 36
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [9*DATA_W-1:0]   kernel_weights,
   input  logic [DATA_W-1:0]     bias,
   output logic [9:0]            in_map_addr,
   input  logic [DATA_W-1:0]     in_map_pixel,
   output logic [9:0]            out_map_addr,
   output logic [DATA_W-1:0]     out_map_pixel,
   output logic                  out_map_write_en,
   output logic                  done,
   output logic                  busy
);
   localparam int AW      = 10;
   localparam int OUT_DIM = IN_DIM - 2;
   localparam int CW      = $clog2(OUT_DIM);
   localparam logic [AW-1:0] IN_A  = AW'(IN_DIM);
   localparam logic [AW-1:0] OUT_A = AW'(OUT_DIM);
   localparam logic [CW-1:0] LAST  = CW'(OUT_DIM - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;
   state_t state;

   logic [CW-1:0]              orow, ocol, nxt_orow, nxt_ocol;
   logic [3:0]                 tap;
   logic signed [ACC_W-1:0]    acc, prod_ext, acc_sum, bias_sh, total, shifted;
   logic signed [DATA_W-1:0]   w_cur;
   logic signed [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]          result, pix_out;
   logic [AW-1:0]              pix_base, nxt_base, out_addr;
   logic                       last_col, last_pix;

   function automatic logic [AW-1:0] tap_off(input logic [3:0] t);
      case (t)
         4'd0:    tap_off = '0;
         4'd1:    tap_off = AW'(1);
         4'd2:    tap_off = AW'(2);
         4'd3:    tap_off = IN_A;
         4'd4:    tap_off = IN_A + AW'(1);
         4'd5:    tap_off = IN_A + AW'(2);
         4'd6:    tap_off = IN_A + IN_A;
         4'd7:    tap_off = IN_A + IN_A + AW'(1);
         4'd8:    tap_off = IN_A + IN_A + AW'(2);
         default: tap_off = '0;
      endcase
   endfunction

   // The pixel arriving in tap cycle t was addressed in cycle t-1, so it pairs with weight t-1.
   always_comb begin
      w_cur = '0;
      for (int k = 0; k < 9; k++)
         if (tap == 4'(k + 1)) w_cur = kernel_weights[k*DATA_W +: DATA_W];
   end

   assign prod     = $signed(in_map_pixel) * w_cur;
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign acc_sum  = acc + prod_ext;
   assign bias_sh  = {{(ACC_W-DATA_W-FRAC_BITS){bias[DATA_W-1]}}, bias, {FRAC_BITS{1'b0}}};
   assign total    = acc_sum + bias_sh;
   assign shifted  = total >>> FRAC_BITS;

   always_comb begin
      if (shifted > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
      else                        result = shifted[DATA_W-1:0];
   end

`ifdef CONV_RELU_EN
   assign pix_out = result[DATA_W-1] ? '0 : result;
`else
   assign pix_out = result;
`endif

   assign last_col = (ocol == LAST);
   assign last_pix = last_col && (orow == LAST);
   assign nxt_ocol = last_col ? '0 : ocol + 1'b1;
   assign nxt_orow = last_col ? orow + 1'b1 : orow;
   assign pix_base = AW'(orow) * IN_A + AW'(ocol);
   assign nxt_base = AW'(nxt_orow) * IN_A + AW'(nxt_ocol);
   assign out_addr = AW'(orow) * OUT_A + AW'(ocol);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         orow             <= '0;
         ocol             <= '0;
         tap              <= '0;
         acc              <= '0;
         in_map_addr      <= '0;
         out_map_addr     <= '0;
         out_map_pixel    <= '0;
         out_map_write_en <= 1'b0;
         done             <= 1'b0;
         busy             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_map_write_en <= 1'b0;
               done             <= 1'b0;
               if (start) begin
                  state       <= MAC;
                  orow        <= '0;
                  ocol        <= '0;
                  tap         <= '0;
                  acc         <= '0;
                  in_map_addr <= '0;
                  busy        <= 1'b1;
               end
            end
            MAC: begin
               if (tap != 4'd0) acc <= acc_sum;
               if (tap < 4'd8) in_map_addr <= pix_base + tap_off(tap + 4'd1);
               if (tap == 4'd9) begin
                  state            <= WRITE;
                  out_map_pixel    <= pix_out;
                  out_map_addr     <= out_addr;
                  out_map_write_en <= 1'b1;
               end else begin
                  tap <= tap + 4'd1;
               end
            end
            WRITE: begin
               out_map_write_en <= 1'b0;
               acc              <= '0;
               tap              <= '0;
               ocol             <= nxt_ocol;
               orow             <= nxt_orow;
               if (last_pix) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state       <= MAC;
                  in_map_addr <= nxt_base;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
